cpu_trig_array: RTL
===================

# cpu_trig_array

Parametrised multi-channel trigger conditioner that turns asynchronous-by-origin, CPU-driven trigger requests into clean, per-channel trigger flags for the acquisition/pulse-generation logic. Each channel runs its own IDLE/ACTIVE/HOLDOFF state machine with a selectable output mode: level follow, single-cycle pulse, or fixed-length stretch. It also enforces a programmable re-arm holdoff and reports triggers it had to drop. The block sits between the PS-side trigger register bits and the downstream sequencer trigger inputs.

## Interface
- NCH, 4, number of independent trigger channels (1..32)
- PULSE_W, 8, width of stretch-length value
- HOLDOFF_W, 16, width of holdoff value

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- CPU_trig  in  NCH  trigger request per channel
- en  in  NCH  per-channel enable; low forces channel to IDLE
- mode  in  2*NCH  per-channel mode, bits [2i+1:2i] for channel i: 00 LEVEL, 01 PULSE, 10 STRETCH, 11 treated as LEVEL
- pulse_len  in  PULSE_W  STRETCH high time in cycles, shared; 0 treated as 1
- holdoff  in  HOLDOFF_W  re-arm holdoff in cycles, shared; 0 = none
- cpu_flag  out  NCH  registered trigger flag per channel
- miss  out  NCH  registered one-cycle pulse: rising edge dropped
- flag_any  out  1  OR of cpu_flag (combinational from registers)

## Operation
- Reset: all states IDLE, cpu_flag=0, miss=0, edge register=0, counters=0; flag_any=0.
- Edge detect: trig_d registers the (optionally synchronised) input each cycle; rise = in & ~trig_d. trig_d resets to 0, so an input held high through reset release counts as a rising edge.
- mode, pulse_len, and holdoff are latched per channel on entry to ACTIVE. Changes during ACTIVE/HOLDOFF do not affect the current trigger.
- IDLE:
  - LEVEL: in=1 -> ACTIVE, flag<=1.
  - PULSE/STRETCH: rise -> ACTIVE, flag<=1, stretch counter<=max(pulse_len,1).
- ACTIVE, LEVEL: in=0 -> flag<=0, then HOLDOFF if holdoff>0, else IDLE.
- ACTIVE, PULSE: next cycle unconditionally -> flag<=0, then HOLDOFF/IDLE as above.
- ACTIVE, STRETCH: counter decrements each cycle; when the counter reaches 1, flag<=0, then HOLDOFF/IDLE. The input is ignored while ACTIVE.
- HOLDOFF: counter loaded with holdoff at flag fall, decrements each cycle, -> IDLE after holdoff cycles. flag stays 0.
- miss<=1 for one cycle on any rise sampled in ACTIVE (PULSE/STRETCH), in HOLDOFF, or on the edge where flag falls. Otherwise miss<=0.
- en=0: next edge state<=IDLE, flag<=0, counters cleared, miss<=0. en re-assertion behaves as IDLE entry, so a high level re-triggers LEVEL mode immediately.
- rst mid-operation overrides everything; outputs are 0 after that edge.

## Timing
- Trigger latency: input sampled high/rising at edge n gives cpu_flag=1 from edge n (visible cycle n+1). Add 2 cycles when synchroniser compiled in.
- LEVEL: flag falls at the first edge sampling in=0.
- PULSE: flag high exactly 1 cycle.
- STRETCH: flag high exactly max(pulse_len,1) cycles.
- Holdoff: flag falls at edge t, rises sampled at edges t..t+H are dropped (miss), and a trigger at edge t+H+1 is accepted. H=0: a trigger at edge t+1 is accepted.
- Channels are fully independent. Simultaneous triggers on several channels all assert on the same edge.

## Configuration
- CPU_TRIG_SYNC_EN defined: each CPU_trig bit passes through a 2-flop synchroniser (reset 0) before edge detect. Latency is +2 cycles, and the input may be asynchronous to clk.
- CPU_TRIG_SYNC_EN undefined: CPU_trig is used directly and must be synchronous to clk.

## Test plan
- LEVEL, holdoff=0: ch0 high for 5 cycles -> cpu_flag[0] high 5 cycles, delayed 1 cycle. flag_any mirrors it. miss=0.
- PULSE: ch1 held high 10 cycles -> cpu_flag[1] high exactly 1 cycle, no retrigger. Drop for 1 cycle and re-raise -> second 1-cycle pulse.
- STRETCH pulse_len=4, holdoff=3: 1-cycle input -> flag 4 cycles. A rise 2 cycles after the fall gives miss=1 and no flag. A rise 4 cycles after the fall gives a new 4-cycle flag.
- STRETCH pulse_len=0: rise -> flag exactly 1 cycle. Changing pulse_len to 9 mid-ACTIVE does not lengthen the flag.
- en cleared on ch2 mid-STRETCH (pulse_len=20): flag drops the next edge. rst asserted mid-ACTIVE on all channels clears cpu_flag/miss to 0.
- Input held high through rst release in PULSE mode -> one 1-cycle flag. With CPU_TRIG_SYNC_EN, all latencies shift by exactly +2 cycles.

Source files
------------

// File: rtl/cpu_trig_array_if.sv
// cpu_trig_array_if: CPU trigger request/flag bundle between the PS trigger
// register bits (master) and the per-channel trigger conditioner (slave).
interface cpu_trig_array_if #(
  parameter int NCH       = 4,
  parameter int PULSE_W   = 8,
  parameter int HOLDOFF_W = 16
);
  logic [NCH-1:0]       CPU_trig;
  logic [NCH-1:0]       en;
  logic [2*NCH-1:0]     mode;
  logic [PULSE_W-1:0]   pulse_len;
  logic [HOLDOFF_W-1:0] holdoff;
  logic [NCH-1:0]       cpu_flag;
  logic [NCH-1:0]       miss;
  logic                 flag_any;

  modport master (
    output CPU_trig, en, mode, pulse_len, holdoff,
    input  cpu_flag, miss, flag_any
  );

  modport slave (
    input  CPU_trig, en, mode, pulse_len, holdoff,
    output cpu_flag, miss, flag_any
  );
endinterface

// File: rtl/cpu_trig_array.sv
// cpu_trig_array: multi-channel trigger conditioner. Each channel runs an
// IDLE/ACTIVE/HOLDOFF machine producing a LEVEL, PULSE or STRETCH flag,
// enforces a re-arm holdoff, and flags rising edges it had to drop (miss).
// Optional: define CPU_TRIG_SYNC_EN to pass CPU_trig through a 2-flop
// synchroniser before edge detection (adds 2 cycles of latency).
module cpu_trig_array #(
  parameter int NCH       = 4,
  parameter int PULSE_W   = 8,
  parameter int HOLDOFF_W = 16
) (
  input logic clk,
  input logic rst,
  cpu_trig_array_if.slave bus
);
  localparam int CNT_W = (PULSE_W > HOLDOFF_W) ? PULSE_W : HOLDOFF_W;

  localparam logic [1:0] M_LEVEL   = 2'b00;
  localparam logic [1:0] M_PULSE   = 2'b01;
  localparam logic [1:0] M_STRETCH = 2'b10;

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} state_t;

  // Mode 11 is reserved and behaves as LEVEL.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    norm_mode = (m == 2'b11) ? M_LEVEL : m;
  endfunction

  // A zero stretch length still yields a one-cycle flag.
  function automatic logic [CNT_W-1:0] stretch_len(input logic [PULSE_W-1:0] len);
    stretch_len = (len == '0) ? CNT_W'(1) : CNT_W'(len);
  endfunction

  logic [NCH-1:0] trig_in;
  logic [NCH-1:0] trig_d;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] flag;
  logic [NCH-1:0] miss;

`ifdef CPU_TRIG_SYNC_EN
  logic [NCH-1:0] sync_p0;
  logic [NCH-1:0] sync_p1;

  // Two-flop synchroniser: CPU_trig may be asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.CPU_trig;
      sync_p1 <= sync_p0;
    end
  end

  assign trig_in = sync_p1;
`else
  assign trig_in = bus.CPU_trig;
`endif

  // Edge register; cleared by reset so a level held through reset is a rise.
  always_ff @(posedge clk) begin
    if (rst) trig_d <= '0;
    else     trig_d <= trig_in;
  end

  assign rise = trig_in & ~trig_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t               state;
    logic [1:0]           mode_l;
    logic [HOLDOFF_W-1:0] hold_l;
    logic [CNT_W-1:0]     cnt;
    logic                 flag_r;
    logic                 miss_r;
    logic [1:0]           mode_in;
    logic                 start;
    logic                 done;

    assign mode_in = norm_mode(bus.mode[2*i +: 2]);
    assign start   = (mode_in == M_LEVEL) ? trig_in[i] : rise[i];
    assign done    = (mode_l == M_LEVEL) ? ~trig_in[i] :
                     (mode_l == M_PULSE) ? 1'b1 : (cnt <= CNT_W'(1));

    // Per-channel trigger state machine with registered flag/miss outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        flag_r <= 1'b0;
        miss_r <= 1'b0;
        cnt    <= '0;
        mode_l <= M_LEVEL;
        hold_l <= '0;
      end else if (!bus.en[i]) begin
        state  <= IDLE;
        flag_r <= 1'b0;
        miss_r <= 1'b0;
        cnt    <= '0;
      end else begin
        miss_r <= 1'b0;
        case (state)
          IDLE: begin
            if (start) begin
              state  <= ACTIVE;
              flag_r <= 1'b1;
              mode_l <= mode_in;
              hold_l <= bus.holdoff;
              cnt    <= stretch_len(bus.pulse_len);
            end
          end
          ACTIVE: begin
            // Rises while a PULSE/STRETCH flag is active (or on its falling
            // edge) cannot start a new trigger and are reported.
            if (mode_l != M_LEVEL) miss_r <= rise[i];
            if (done) begin
              flag_r <= 1'b0;
              if (hold_l != '0) begin
                state <= HOLDOFF;
                cnt   <= CNT_W'(hold_l);
              end else begin
                state <= IDLE;
                cnt   <= '0;
              end
            end else if (mode_l == M_STRETCH) begin
              cnt <= cnt - 1'b1;
            end
          end
          HOLDOFF: begin
            miss_r <= rise[i];
            if (cnt <= CNT_W'(1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            flag_r <= 1'b0;
            cnt    <= '0;
          end
        endcase
      end
    end

    assign flag[i] = flag_r;
    assign miss[i] = miss_r;
  end

  assign bus.cpu_flag = flag;
  assign bus.miss     = miss;
  assign bus.flag_any = |flag;
endmodule
